// File: rtl/warp_scheduler.sv
// Per-core instruction sequencer: walks one instruction at a time through
// fetch, decode, memory request/wait, execute and writeback for a block.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for the dispatcher's start
// FETCH   | fetch_req held until the fetcher reports a valid instruction
// DECODE  | one-cycle decode pulse; op flags latched on exit
// REQUEST | one-cycle LSU request pulse to active threads (memory ops)
// WAIT    | retire LSU completions until no thread is pending
// EXECUTE | one-cycle ALU/LSU result-valid pulse
// UPDATE  | writeback pulse; advance pc or finish on HALT
// DONE    | block finished; held until start drops
module warp_scheduler #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [THREADS-1:0] thread_mask,
  output logic               fetch_req,
  input  logic               fetch_done,
  output logic               decode_en,
  input  logic               is_ldr,
  input  logic               is_str,
  input  logic               is_halt,
  output logic [THREADS-1:0] mem_req,
  input  logic [THREADS-1:0] mem_done,
  output logic               execute_en,
  output logic               update_en,
  input  logic [PC_BITS-1:0] next_pc,
  output logic [PC_BITS-1:0] pc,
  output logic [2:0]         state,
  output logic               done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_REQUEST = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_EXECUTE = 3'd5;
  localparam logic [2:0] S_UPDATE  = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic [PC_BITS-1:0] pc_q;
  logic [THREADS-1:0] act_mask;
  logic [THREADS-1:0] pending;
  logic               mem_op;
  logic               halt_op;
  logic               wait_clear;

  // Exit WAIT only on a cycle that begins with nothing outstanding, so a
  // non-memory instruction still spends exactly one cycle here.
  assign wait_clear = (pending == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_done) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_REQUEST;
      end
      S_REQUEST: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_clear) state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (halt_op) state_d = S_DONE;
        else         state_d = S_FETCH;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // pc only ever takes next_pc verbatim; overflow is the PC unit's concern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        pc_q <= '0;
      end else if (state_q == S_UPDATE && !halt_op) begin
        pc_q <= next_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_mask <= '0;
    end else if (state_q == S_IDLE && start) begin
      act_mask <= thread_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_op  <= 1'b0;
      halt_op <= 1'b0;
    end else if (state_q == S_DECODE) begin
      mem_op  <= is_ldr | is_str;
      halt_op <= is_halt;
    end
  end

  // Completions for threads that were never requested fall away in the AND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      case (state_q)
        S_REQUEST: pending <= mem_op ? act_mask : '0;
        S_WAIT:    pending <= pending & ~mem_done;
        S_IDLE:    pending <= '0;
        default:   pending <= pending;
      endcase
    end
  end

  assign fetch_req  = (state_q == S_FETCH);
  assign decode_en  = (state_q == S_DECODE);
  assign mem_req    = (state_q == S_REQUEST && mem_op) ? act_mask : '0;
  assign execute_en = (state_q == S_EXECUTE);
  assign update_en  = (state_q == S_UPDATE);
  assign done       = (state_q == S_DONE);
  assign pc         = pc_q;
  assign state      = state_q;

endmodule
